// File: rtl/axis_bram_frame_reader_pkg.sv
// Shared types and the sum-scaling helper for the complex averager readout.
// AXIS_BRAM_FRAME_READER_SATURATE_EN selects saturation instead of wrap-around.
package axis_bram_frame_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    localparam int DEF_FRAME_LOG_LENGTH = 10;
    localparam int FRAME_LENGTH = 1 << DEF_FRAME_LOG_LENGTH;
    localparam int SUM_W = 32;
    localparam int HALF_W = 16;

    function automatic logic [HALF_W-1:0] scale(
        input logic [SUM_W-1:0] sum,
        input logic [4:0]       sh
    );
        logic signed [SUM_W-1:0] s;
        s = $signed(sum) >>> sh;
`ifdef AXIS_BRAM_FRAME_READER_SATURATE_EN
        if (s > 32'sd32767)
            scale = 16'h7FFF;
        else if (s < -32'sd32768)
            scale = 16'h8000;
        else
            scale = s[HALF_W-1:0];
`else
        scale = s[HALF_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/axis_skid_buffer2.sv
// Two-entry FIFO between the BRAM read pipeline and the AXIS output.
// Head entry drives the output; valid is purely occupancy-based.
module axis_skid_buffer2
    import axis_bram_frame_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = (r_count != 2'd0) & i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0)
                        r_head <= i_data;
                    else
                        r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_bram_frame_reader.sv
// Reads one frame of complex sums from BRAM port B and streams them scaled.
// Define AXIS_BRAM_FRAME_READER_SATURATE_EN to saturate instead of truncate.
module axis_bram_frame_reader
    import axis_bram_frame_reader_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 64,
    parameter int BRAM_ADDR_WIDTH  = 32,
    parameter int FRAME_LOG_LENGTH = DEF_FRAME_LOG_LENGTH
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start,
    input  logic [4:0]                  AV_log_count,
    output logic                        busy,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tlast,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
    output logic                        bram_portb_clk,
    output logic                        bram_portb_en,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata
);

    localparam int BH = BRAM_DATA_WIDTH / 2;
    localparam int AW = AXIS_TDATA_WIDTH;
    localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR =
        BRAM_ADDR_WIDTH'((1 << FRAME_LOG_LENGTH) - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [4:0]                 r_log;
    logic [BRAM_ADDR_WIDTH-1:0] r_rd_addr;
    logic                       r_inflight;
    logic                       r_inflight_last;
    logic                       w_issue;
    logic                       w_pop;
    logic                       w_final;
    logic                       w_valid;
    logic [1:0]                 w_count;
    logic [2:0]                 w_pending;
    logic [AW:0]                w_push_data;
    logic [AW:0]                w_head;

    assign w_pop     = w_valid & M_AXIS_tready;
    assign w_final   = w_pop & w_head[AW];
    assign w_pending = {1'b0, w_count} + {2'b00, r_inflight};

    // A beat leaving this cycle frees a slot, so sustained rate is one per cycle
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_READ;
            end
            S_READ: begin
                w_issue = (w_pending < 3'd2) ||
                          ((w_pending == 3'd2) && w_pop);
                if (w_issue && (r_rd_addr == LAST_ADDR))
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_final)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state         <= S_IDLE;
            r_log           <= 5'd0;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == LAST_ADDR);
            if ((r_state == S_IDLE) && start)
                r_log <= AV_log_count;
            if (w_issue) begin
                if (r_rd_addr == LAST_ADDR)
                    r_rd_addr <= '0;
                else
                    r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    assign w_push_data = {
        r_inflight_last,
        scale(bram_portb_rddata[BRAM_DATA_WIDTH-1:BH], r_log),
        scale(bram_portb_rddata[BH-1:0], r_log)
    };

    axis_skid_buffer2 #(
        .WIDTH(AW + 1)
    ) u_skid (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_ready (M_AXIS_tready),
        .o_valid (w_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign busy            = (r_state != S_IDLE);
    assign M_AXIS_tvalid   = w_valid;
    assign M_AXIS_tdata    = w_head[AW-1:0];
    assign M_AXIS_tlast    = w_valid & w_head[AW];
    assign bram_portb_addr = r_rd_addr;
    assign bram_portb_en   = w_issue;
    assign bram_portb_clk  = aclk;

endmodule

// File: tb/tb_axis_bram_frame_reader.sv
// Scoreboard bench for axis_bram_frame_reader with a 4-word frame.
// Honours AXIS_BRAM_FRAME_READER_SATURATE_EN for the clipping vectors.
module tb_axis_bram_frame_reader;

    localparam int LOGN = 2;
    localparam int N    = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  log_count = 5'd0;
    logic        busy;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic [31:0] addr;
    logic        bclk;
    logic        en;
    logic [63:0] rddata = 64'd0;

    logic [63:0] mem [N];
    logic [32:0] basic_exp [N];
    logic [32:0] sb [$];

    int   vectors = 0;
    int   miscompares = 0;
    int   outstanding = 0;
    logic mon_stall = 1'b0;
    logic [32:0] mon_prev = 33'd0;

    axis_bram_frame_reader #(
        .AXIS_TDATA_WIDTH (32),
        .BRAM_DATA_WIDTH  (64),
        .BRAM_ADDR_WIDTH  (32),
        .FRAME_LOG_LENGTH (LOGN)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start             (start),
        .AV_log_count      (log_count),
        .busy              (busy),
        .M_AXIS_tdata      (tdata),
        .M_AXIS_tvalid     (tvalid),
        .M_AXIS_tready     (tready),
        .M_AXIS_tlast      (tlast),
        .bram_portb_addr   (addr),
        .bram_portb_clk    (bclk),
        .bram_portb_en     (en),
        .bram_portb_rddata (rddata)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk)
        if (en)
            rddata <= mem[addr[LOGN-1:0]];

    always @(negedge aclk) begin
        if (aresetn) begin
            if (mon_stall) begin
                vectors++;
                if ({tvalid, tlast, tdata} !== {1'b1, mon_prev}) begin
                    miscompares++;
                    $display("FAIL stall_hold got v=%b %h want v=1 %h",
                             tvalid, {tlast, tdata}, mon_prev);
                end
            end
            mon_stall = tvalid && !tready;
            mon_prev  = {tlast, tdata};
            outstanding = outstanding + int'(en) - int'(tvalid && tready);
            if (en) begin
                vectors++;
                if (outstanding > 2) begin
                    miscompares++;
                    $display("FAIL outstanding got %0d want <=2", outstanding);
                end
            end
            if (tvalid && tready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat got %h want none",
                             {tlast, tdata});
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    if ({tlast, tdata} !== e) begin
                        miscompares++;
                        $display("FAIL beat got %h want %h", {tlast, tdata}, e);
                    end
                end
            end
        end
    end

    task automatic load_basic();
        mem[0] = {32'd1, 32'd0};
        mem[1] = {32'd2, 32'd8};
        mem[2] = {32'd3, 32'hFFFF_FFF8};
        mem[3] = {32'd4, 32'd100};
        for (int i = 0; i < N; i++)
            sb.push_back(basic_exp[i]);
    endtask

    task automatic pulse_start(input logic [4:0] sh);
        @(posedge aclk);
        #1 start = 1'b1;
        log_count = sh;
        @(posedge aclk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge aclk);
            if (!busy && sb.size() == 0)
                done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_timeout got busy=%b left=%0d want idle empty",
                     name, busy, sb.size());
        end
    endtask

    task automatic test_reset();
        #2 aresetn = 1'b0;
        start = 1'b0;
        tready = 1'b0;
        @(posedge aclk);
        #1;
        vectors++;
        if ({busy, tvalid, tlast, en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 0000", {busy, tvalid, tlast, en});
        end
        vectors++;
        if (tdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_tdata got %h want 0", tdata);
        end
        vectors++;
        if (addr !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_addr got %h want 0", addr);
        end
        @(negedge aclk);
        outstanding = 0;
        mon_stall = 1'b0;
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        load_basic();
        tready = 1'b1;
        pulse_start(5'd2);
        @(negedge aclk);
        vectors++;
        if ({busy, tvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_e0 got %b want 10", {busy, tvalid});
        end
        @(negedge aclk);
        vectors++;
        if (tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_e1_valid got %b want 0", tvalid);
        end
        @(negedge aclk);
        vectors++;
        if (tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_e2_valid got %b want 1", tvalid);
        end
        repeat (3) @(negedge aclk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_e5_busy got %b want 1", busy);
        end
        @(negedge aclk);
        vectors++;
        if ({busy, tvalid, sb.size() == 0} !== 3'b001) begin
            miscompares++;
            $display("FAIL basic_e6_done got %b want 001",
                     {busy, tvalid, sb.size() == 0});
        end
    endtask

    task automatic test_backpressure();
        bit done;
        load_basic();
        tready = 1'b1;
        pulse_start(5'd2);
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge aclk);
            if (!busy && sb.size() == 0)
                done = 1'b1;
            @(posedge aclk);
            #1 tready = ((c % 3) == 2);
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL backpressure_timeout got left=%0d want 0", sb.size());
        end
        tready = 1'b1;
    endtask

    task automatic test_stall_start();
        int n_rd;
        load_basic();
        tready = 1'b0;
        n_rd = 0;
        pulse_start(5'd2);
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            if (en)
                n_rd++;
            if (k == 2) begin
                vectors++;
                if ({tvalid, tlast, tdata} !== {1'b1, basic_exp[0]}) begin
                    miscompares++;
                    $display("FAIL stall_first got %b %h want 1 %h",
                             tvalid, {tlast, tdata}, basic_exp[0]);
                end
            end
        end
        vectors++;
        if (n_rd != 2) begin
            miscompares++;
            $display("FAIL stall_reads got %0d want 2", n_rd);
        end
        @(posedge aclk);
        #1 tready = 1'b1;
        wait_idle("stall");
    endtask

    task automatic test_trunc();
        mem[0] = {32'd0, 32'h0001_0000};
        mem[1] = {32'd0, 32'hFFFE_0000};
        mem[2] = 64'd0;
        mem[3] = 64'd0;
`ifdef AXIS_BRAM_FRAME_READER_SATURATE_EN
        sb.push_back({1'b0, 16'h0000, 16'h7FFF});
        sb.push_back({1'b0, 16'h0000, 16'h8000});
`else
        sb.push_back({1'b0, 16'h0000, 16'h0000});
        sb.push_back({1'b0, 16'h0000, 16'h0000});
`endif
        sb.push_back({1'b0, 16'h0000, 16'h0000});
        sb.push_back({1'b1, 16'h0000, 16'h0000});
        tready = 1'b1;
        pulse_start(5'd0);
        wait_idle("trunc");
    endtask

    task automatic test_start_ignored();
        int bad;
        load_basic();
        tready = 1'b1;
        pulse_start(5'd2);
        @(posedge aclk);
        @(posedge aclk);
        #1 start = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        #1 start = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (busy || tvalid)
                bad++;
        end
        vectors++;
        if (bad != 0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL start_ignored got busy_cycles=%0d left=%0d want 0 0",
                     bad, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        load_basic();
        tready = 1'b1;
        pulse_start(5'd2);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        vectors++;
        if (tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_valid got %b want 1", tvalid);
        end
        #1 aresetn = 1'b0;
        #1;
        vectors++;
        if ({tvalid, tlast, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_async got %b want 000", {tvalid, tlast, busy});
        end
        sb.delete();
        @(negedge aclk);
        outstanding = 0;
        mon_stall = 1'b0;
        aresetn = 1'b1;
        load_basic();
        pulse_start(5'd2);
        wait_idle("after_reset");
    endtask

    initial begin
        basic_exp[0] = {1'b0, 16'h0000, 16'h0000};
        basic_exp[1] = {1'b0, 16'h0000, 16'h0002};
        basic_exp[2] = {1'b0, 16'h0000, 16'hFFFE};
        basic_exp[3] = {1'b1, 16'h0001, 16'h0019};
        for (int i = 0; i < N; i++)
            mem[i] = 64'd0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stall_start();
        test_trunc();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
